// File: rtl/tdm_mux_81.sv
// 8:1 TDM transmitter: loads an N_CH-bit frame and serialises it one channel per beat with its index.
// Optional parity beat after the last data beat when TDM_PARITY_EN is defined.
module tdm_mux_81 #(
    parameter int   SEL_W    = 3,
    parameter logic IDLE_VAL = 1'b0,
    localparam int  N_CH     = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  in_frame,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             out_par
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [N_CH-1:0]   frame, frame_nxt;
    logic [SEL_W-1:0]  sel, sel_nxt;
    logic              final_hs;
    logic              accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            frame <= '0;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            frame <= frame_nxt;
            sel   <= sel_nxt;
        end
    end

    // Beat outputs come straight from registered state, so they stay put while stalled.
    always_comb begin
        out_valid = 1'b0;
        out_bit   = IDLE_VAL;
        out_sel   = '0;
        out_last  = 1'b0;
        out_par   = 1'b0;
        case (state)
            SEND: begin
                out_valid = 1'b1;
                out_bit   = frame[sel];
                out_sel   = sel;
`ifdef TDM_PARITY_EN
                out_last  = 1'b0;
`else
                out_last  = (sel == LAST_SEL);
`endif
            end
`ifdef TDM_PARITY_EN
            PAR: begin
                out_valid = 1'b1;
                out_bit   = ^frame;
                out_sel   = LAST_SEL;
                out_last  = 1'b1;
                out_par   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // The last beat's handshake frees the frame register for a gap-free reload.
    assign final_hs = out_valid & out_ready & out_last;
    assign in_ready = (state == IDLE) | final_hs;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_nxt = state;
        frame_nxt = frame;
        sel_nxt   = sel;
        case (state)
            SEND: begin
                if (out_ready) begin
                    if (sel == LAST_SEL) begin
`ifdef TDM_PARITY_EN
                        state_nxt = PAR;
`else
                        state_nxt = IDLE;
`endif
                    end else begin
                        sel_nxt = sel + 1'b1;
                    end
                end
            end
`ifdef TDM_PARITY_EN
            PAR: begin
                if (out_ready) state_nxt = IDLE;
            end
`endif
            default: ;
        endcase
        if (accept) begin
            frame_nxt = in_frame;
            sel_nxt   = '0;
            state_nxt = SEND;
        end
    end

endmodule
